// File: rtl/hex_word_ascii_tx_pkg.sv
// Shared constants and FSM encoding for the hex-word ASCII transmitter.
package hex_word_ascii_tx_pkg;

  localparam logic [7:0] CHAR_CR   = 8'h0d;
  localparam logic [7:0] CHAR_LF   = 8'h0a;
  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_A_LC = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_CR    = 2'd2,
    ST_LF    = 2'd3
  } state_e;

  // A single-digit word still needs a 1-bit counter.
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/hex_word_ascii_tx_nibble2ascii.sv
// Combinational nibble to lowercase ASCII hex digit; inverse of the ASCII-to-nibble decoder.
module nibble2ascii
  import hex_word_ascii_tx_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char
);

  // Digits 0-9 map onto '0'..'9', 10-15 onto 'a'..'f'.
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_char = CHAR_0 + {4'h0, i_nibble};
    end else begin
      o_char = CHAR_A_LC + {4'h0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_ascii_tx.sv
// Serialises a word into lowercase ASCII hex characters, MSB nibble first,
// optionally followed by CR LF, one character per valid/ready handshake.
module hex_word_ascii_tx
  import hex_word_ascii_tx_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter bit APPEND_NEWLINE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int DIGITS = DATA_W / 4;
  localparam int CNT_W  = cnt_width(DIGITS);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [7:0]          r_out_char;
  logic                r_out_last;
  logic                r_out_valid;
  logic                r_in_ready;
  logic                r_busy;
  logic [7:0]          w_digit_char;
  logic [7:0]          w_char_nxt;
  logic                w_last_nxt;

  // Outputs are precomputed from the next state so they are registered yet zero-latency.
  nibble2ascii u_nibble2ascii (
    .i_nibble (w_shift_nxt[DATA_W-1 -: 4]),
    .o_char   (w_digit_char)
  );

  // Next-state, shift-register and digit-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_shift_nxt = in_data;
          w_cnt_nxt   = CNT_W'(DIGITS - 1);
          w_state_nxt = ST_DIGIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DIGIT: begin
        if (out_ready) begin
          w_shift_nxt = r_shift << 4;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(0)) begin
            w_state_nxt = APPEND_NEWLINE ? ST_CR : ST_IDLE;
          end else begin
            w_state_nxt = ST_DIGIT;
          end
        end else begin
          w_state_nxt = ST_DIGIT;
        end
      end
      ST_CR: begin
        if (out_ready) begin
          w_state_nxt = ST_LF;
        end else begin
          w_state_nxt = ST_CR;
        end
      end
      ST_LF: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LF;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Character and last flag to present once the next state is entered.
  always_comb begin
    w_char_nxt = 8'h00;
    w_last_nxt = 1'b0;
    case (w_state_nxt)
      ST_DIGIT: begin
        w_char_nxt = w_digit_char;
        w_last_nxt = !APPEND_NEWLINE && (w_cnt_nxt == CNT_W'(0));
      end
      ST_CR: begin
        w_char_nxt = CHAR_CR;
        w_last_nxt = 1'b0;
      end
      ST_LF: begin
        w_char_nxt = CHAR_LF;
        w_last_nxt = 1'b1;
      end
      default: begin
        w_char_nxt = 8'h00;
        w_last_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_out_char  <= 8'h00;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_char  <= w_char_nxt;
      r_out_last  <= w_last_nxt;
      r_out_valid <= (w_state_nxt != ST_IDLE);
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_hex_word_ascii_tx.sv
// Directed bench for hex_word_ascii_tx: queue-based character model plus literal pins.
module tb_hex_word_ascii_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
  logic [31:0] in_data_a;
  logic [7:0]  out_char_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
  logic [7:0]  in_data_b;
  logic [7:0]  out_char_b;
  logic [3:0]  nib;
  logic [7:0]  nib_ch;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit rand_a = 1'b0;

  logic [8:0]  qa[$];
  logic [8:0]  qb[$];
  logic [7:0]  cap_ch[$];
  logic        cap_last[$];
  int          cap_cy[$];
  logic [7:0]  capb_ch[$];
  logic        capb_last[$];
  int          acc_cyc_a;

  always #5 clk = ~clk;

  hex_word_ascii_tx #(.DATA_W(32), .APPEND_NEWLINE(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_char(out_char_a), .out_last(out_last_a), .busy(busy_a)
  );

  hex_word_ascii_tx #(.DATA_W(8), .APPEND_NEWLINE(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_char(out_char_b), .out_last(out_last_b), .busy(busy_b)
  );

  nibble2ascii u_n2a (.i_nibble(nib), .o_char(nib_ch));

  function automatic logic [7:0] hexch(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(97 + n - 10);
  endfunction

  // Reference ASCII-to-nibble decoder; -1 marks an illegal code.
  function automatic int dec(input logic [7:0] c);
    if (c >= 8'd48 && c <= 8'd57) return int'(c) - 48;
    if (c >= 8'd97 && c <= 8'd102) return int'(c) - 87;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process for the 32-bit instance.
  initial begin
    logic [7:0] prev_char;
    logic       prev_last, prev_stall;
    logic [8:0] e;
    prev_stall = 1'b0; prev_char = 8'h00; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qa.delete();
        prev_stall = 1'b0;
      end else begin
        check("a_busy",  32'(busy_a),      32'(qa.size() != 0));
        check("a_valid", 32'(out_valid_a), 32'(qa.size() != 0));
        check("a_ready", 32'(in_ready_a),  32'(qa.size() == 0));
        if (prev_stall) begin
          check("a_hold_char", 32'(out_char_a), 32'(prev_char));
          check("a_hold_last", 32'(out_last_a), 32'(prev_last));
        end
        if (out_valid_a && out_ready_a) begin
          cap_ch.push_back(out_char_a); cap_last.push_back(out_last_a); cap_cy.push_back(cyc);
          if (qa.size() != 0) begin
            e = qa.pop_front();
            check("a_char", 32'(out_char_a), 32'(e[7:0]));
            check("a_last", 32'(out_last_a), 32'(e[8]));
          end
        end
        prev_stall = out_valid_a && !out_ready_a;
        prev_char  = out_char_a;
        prev_last  = out_last_a;
        if (in_valid_a && in_ready_a) begin
          acc_cyc_a = cyc;
          for (int i = 0; i < 8; i++) qa.push_back({1'b0, hexch(int'((in_data_a >> (28 - 4*i)) & 32'hf))});
          qa.push_back({1'b0, 8'h0d});
          qa.push_back({1'b1, 8'h0a});
        end
      end
    end
  end

  // Compare process for the 8-bit, no-newline instance.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qb.delete();
      end else begin
        check("b_busy",  32'(busy_b),      32'(qb.size() != 0));
        check("b_valid", 32'(out_valid_b), 32'(qb.size() != 0));
        if (out_valid_b && out_ready_b) begin
          capb_ch.push_back(out_char_b); capb_last.push_back(out_last_b);
          if (qb.size() != 0) begin
            e = qb.pop_front();
            check("b_char", 32'(out_char_b), 32'(e[7:0]));
            check("b_last", 32'(out_last_b), 32'(e[8]));
          end
        end
        if (in_valid_b && in_ready_b) begin
          for (int i = 0; i < 2; i++) qb.push_back({1'(i == 1), hexch(int'((in_data_b >> (4 - 4*i)) & 8'hf))});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready_a = rand_a ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_a(input logic [31:0] w);
    in_valid_a = 1'b1;
    in_data_a  = w;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready_a) begin
        tick();
        in_valid_a = 1'b0;
        return;
      end
      tick();
    end
    in_valid_a = 1'b0;
    timeout("a_accept");
  endtask

  task automatic wait_idle_a();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy_a) begin
        tick();
        return;
      end
      tick();
    end
    timeout("a_idle");
  endtask

  localparam logic [7:0] EXP1 [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64, 8'h0d, 8'h0a};

  initial begin
    int hs;
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_data_a = 32'h0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = 8'h0;  out_ready_b = 1'b1;
    nib = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_char", 32'(out_char_a), 32'h00);
    check("rst_out_last", 32'(out_last_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    tick();

    // 1: full-rate word with newline
    cap_ch.delete(); cap_last.delete(); cap_cy.delete();
    send_a(32'h1234abcd);
    wait_idle_a();
    check("t1_count", 32'(cap_ch.size()), 32'd10);
    if (cap_ch.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        check("t1_char", 32'(cap_ch[i]), 32'(EXP1[i]));
        check("t1_last", 32'(cap_last[i]), 32'(i == 9));
        check("t1_cycle", 32'(cap_cy[i]), 32'(acc_cyc_a + 1 + i));
      end
    end

    // 2: random backpressure, second word queued while busy
    rand_a = 1'b1;
    cap_ch.delete(); cap_last.delete(); cap_cy.delete();
    send_a(32'hffffffff);
    send_a(32'h00000000);
    wait_idle_a();
    rand_a = 1'b0;
    tick();
    check("t2_count", 32'(cap_ch.size()), 32'd20);
    if (cap_ch.size() == 20) begin
      check("t2_first_f", 32'(cap_ch[0]), 32'h66);
      check("t2_lf1", 32'(cap_ch[9]), 32'h0a);
      check("t2_first_0", 32'(cap_ch[10]), 32'h30);
    end

    // 3: reset after the third handshake
    cap_ch.delete(); cap_last.delete(); cap_cy.delete();
    send_a(32'hdeadbeef);
    hs = 0;
    for (int k = 0; k < 50 && hs < 3; k++) begin
      @(negedge clk);
      if (out_valid_a && out_ready_a) hs++;
      if (hs < 3) tick();
    end
    check("t3_hs", 32'(hs), 32'd3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t3_out_valid", 32'(out_valid_a), 32'd0);
    check("t3_in_ready", 32'(in_ready_a), 32'd1);
    check("t3_busy", 32'(busy_a), 32'd0);
    if (cap_ch.size() >= 3) check("t3_third", 32'(cap_ch[2]), 32'h61);
    tick();
    cap_ch.delete(); cap_last.delete(); cap_cy.delete();
    send_a(32'h00000007);
    wait_idle_a();
    check("t3_count", 32'(cap_ch.size()), 32'd10);
    if (cap_ch.size() == 10) check("t3_seven", 32'(cap_ch[7]), 32'h37);

    // 4: new data offered while busy must be ignored
    cap_ch.delete(); cap_last.delete(); cap_cy.delete();
    send_a(32'hcafe0123);
    in_valid_a = 1'b1;
    in_data_a  = 32'h55555555;
    @(negedge clk);
    check("t4_in_ready", 32'(in_ready_a), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    in_valid_a = 1'b0;
    wait_idle_a();
    repeat (3) tick();
    check("t4_count", 32'(cap_ch.size()), 32'd10);

    // 5: narrow instance without newline
    in_valid_b = 1'b1;
    in_data_b  = 8'h9a;
    @(negedge clk);
    check("t5_ready", 32'(in_ready_b), 32'd1);
    @(posedge clk); #1 in_valid_b = 1'b0;
    for (int k = 0; k < 20 && busy_b; k++) begin
      @(negedge clk);
      if (busy_b) @(posedge clk);
    end
    repeat (2) @(negedge clk);
    check("t5_count", 32'(capb_ch.size()), 32'd2);
    if (capb_ch.size() == 2) begin
      check("t5_c0", 32'(capb_ch[0]), 32'h39);
      check("t5_c1", 32'(capb_ch[1]), 32'h61);
      check("t5_l0", 32'(capb_last[0]), 32'd0);
      check("t5_l1", 32'(capb_last[1]), 32'd1);
    end
    check("t5_idle", 32'(in_ready_b), 32'd1);

    // 6: nibble round trip through the reference decoder
    for (int n = 0; n < 16; n++) begin
      nib = 4'(n);
      #1;
      check("t6_roundtrip", 32'(dec(nib_ch)), 32'(n));
      check("t6_char", 32'(nib_ch), 32'(hexch(n)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
